// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, immediate formats, datapath mux codes,
// instruction classes and the control FSM state encoding.
package rv32i_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // Immediate format select, shared with imm_gen.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_FUNC = 2'd1;
  localparam logic [1:0] ALU_CMP  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_OP,
    CL_OP_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_FENCE,
    CL_SYSTEM,
    CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: instruction class, immediate format and
// illegal flag from the 7-bit major opcode.
module opcode_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic [2:0] imm_sel,
  output logic       illegal
);

  always_comb begin
    iclass  = CL_ILLEGAL;
    imm_sel = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP:      iclass = CL_OP;
      OP_IMM:  iclass = CL_OP_IMM;
      LOAD:    iclass = CL_LOAD;
      STORE: begin
        iclass  = CL_STORE;
        imm_sel = IMM_S;
      end
      BRANCH: begin
        iclass  = CL_BRANCH;
        imm_sel = IMM_B;
      end
      JAL: begin
        iclass  = CL_JAL;
        imm_sel = IMM_J;
      end
      JALR:    iclass = CL_JALR;
      LUI: begin
        iclass  = CL_LUI;
        imm_sel = IMM_U;
      end
      AUIPC: begin
        iclass  = CL_AUIPC;
        imm_sel = IMM_U;
      end
      FENCE:   iclass = CL_FENCE;
      SYSTEM:  iclass = CL_SYSTEM;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback over a
// single-port memory, driving all datapath enables and mux selects.
module ctrl_fsm
  import rv32i_pkg::*;
#(
  parameter int RESET_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_mode,
  output logic [2:0]  imm_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        illegal,
  output logic        halted
);

  localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        illegal_reg, illegal_next;
  logic        halted_reg, halted_next;

  iclass_t     dec_class;
  logic [2:0]  dec_imm_sel;
  logic        dec_illegal;
  logic        rd_zero;
  logic        unused_instr_bits;

  opcode_decode u_decode (
    .opcode  (instr_in[6:0]),
    .iclass  (dec_class),
    .imm_sel (dec_imm_sel),
    .illegal (dec_illegal)
  );

  assign rd_zero           = (instr_in[11:7] == 5'd0);
  assign unused_instr_bits = ^instr_in[31:12];
  assign illegal           = illegal_reg;
  assign halted            = halted_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      illegal_reg  <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      illegal_reg  <= illegal_next;
      halted_reg   <= halted_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    illegal_next  = illegal_reg;
    halted_next   = halted_reg;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PC_PLUS4;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    alu_mode      = ALU_ADD;
    imm_sel       = IMM_I;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;

    // imm_gen sees the decoded format for as long as IR holds the instruction.
    if (state_reg inside {S_DECODE, S_EXEC, S_MEM, S_WB})
      imm_sel = dec_imm_sel;

    case (state_reg)
      S_IDLE: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          wait_cnt_next = 4'd0;
          state_next    = S_FETCH;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        if (mem_ready)
          state_next = S_DECODE;
      end

      S_DECODE: begin
        if (dec_illegal) begin
          illegal_next = 1'b1;
          halted_next  = 1'b1;
          state_next   = S_HALT;
        end else if (dec_class == CL_SYSTEM) begin
          halted_next  = 1'b1;
          state_next   = S_HALT;
        end else begin
          state_next   = S_EXEC;
        end
      end

      S_EXEC: begin
        case (dec_class)
          CL_OP: begin
            alu_mode   = ALU_FUNC;
            state_next = S_WB;
          end
          CL_OP_IMM: begin
            alu_mode   = ALU_FUNC;
            alu_b_sel  = 1'b1;
            state_next = S_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_b_sel  = 1'b1;
            state_next = S_MEM;
          end
          CL_BRANCH: begin
            alu_mode   = ALU_CMP;
            pc_we      = 1'b1;
            pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
            state_next = S_FETCH;
          end
          CL_JAL: begin
            pc_src     = PC_IMM;
            state_next = S_WB;
          end
          CL_JALR: begin
            alu_b_sel  = 1'b1;
            pc_src     = PC_ALU;
            state_next = S_WB;
          end
          CL_LUI:   state_next = S_WB;
          CL_AUIPC: begin
            alu_a_sel  = 1'b1;
            alu_b_sel  = 1'b1;
            state_next = S_WB;
          end
          CL_FENCE: begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end
          default: begin
            halted_next = 1'b1;
            state_next  = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_class == CL_STORE);
        if (mem_ready) begin
          if (dec_class == CL_STORE) begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end

      S_WB: begin
        pc_we      = 1'b1;
        rf_we      = !rd_zero;
        state_next = S_FETCH;
        case (dec_class)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_IMM;
          end
          CL_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
          CL_LUI:  wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_IDLE;
    endcase
  end

endmodule
